// File: rtl/mux_arbiter.sv
// Purpose: 4-way round-robin arbiter driving a registered-select data mux.
// Latency: 1 cycle from req to gnt/sel/valid; out follows sel combinationally.
// Backpressure: none; a requester holds req until done, the owner keeps the grant while req[sel]=1.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   req[3:0]              - request per requester
//   in0..in3[WIDTH-1:0]   - requester data
//   gnt[3:0]              - one-hot grant (registered)
//   sel[1:0]              - index of current / most recent owner (registered)
//   out[WIDTH-1:0]        - in[sel] while valid, else zero
//   valid                 - gnt non-zero (registered)
//   timeout               - one-cycle pulse on a forced rotation
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD
// cycles when another requester is waiting. Without it timeout is tied to 0.
module mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic       valid_q, valid_d;

    // Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + k[1:0];
            if (mask[cand] && !found) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [2:0] pick_any;
    logic       do_grant;
    logic [1:0] grant_idx;
    logic       go_idle;

    assign pick_any = rr_pick(req, last_q);

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_q,    hold_d;
    logic       timeout_q, timeout_d;
    logic [2:0] pick_other;

    // Candidates for a forced rotation exclude the current owner.
    assign pick_other = rr_pick(req & ~(4'b0001 << sel_q), last_q);
`endif

    always_comb begin
        do_grant  = 1'b0;
        grant_idx = pick_any[1:0];
        go_idle   = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pick_any[2]) begin
                    do_grant = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    // Owner released: hand over on the same edge if anyone waits.
                    if (pick_any[2]) begin
                        do_grant = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    if (hold_q == 8'(MAX_HOLD - 1)) begin
                        // Limit reached: rotate only if someone else waits,
                        // otherwise keep the owner with the counter saturated.
                        if (pick_other[2]) begin
                            do_grant  = 1'b1;
                            grant_idx = pick_other[1:0];
                            timeout_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
            end
            default: go_idle = 1'b1;
        endcase

        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (do_grant) begin
            state_d = BUSY;
            gnt_d   = 4'b0001 << grant_idx;
            sel_d   = grant_idx;
            last_d  = grant_idx;
            valid_d = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_d  = 8'd0;
`endif
        end else if (go_idle) begin
            // sel keeps the previous owner index.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;   // first search after reset starts at requester 0
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Output mux; gated by valid so out is zero whenever there is no owner.
    always_comb begin
        out = '0;
        if (valid_q) begin
            case (sel_q)
                2'd0:    out = in0;
                2'd1:    out = in1;
                2'd2:    out = in2;
                default: out = in3;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with a scoreboard of expected output records.
module tb_mux_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             timeout;

    typedef struct packed {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic [WIDTH-1:0] out;
        logic             valid;
        logic             timeout;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_fail;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .gnt     (gnt),
        .sel     (sel),
        .out     (out),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [3:0] eg, input logic [1:0] es,
                            input logic [WIDTH-1:0] eo, input logic ev, input logic et);
        exp_t e;
        e.gnt     = eg;
        e.sel     = es;
        e.out     = eo;
        e.valid   = ev;
        e.timeout = et;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        exp_t  o;
        string t;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed output with no expected entry, required an entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {gnt, sel, out, valid, timeout};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b sel=%b out=%b valid=%b timeout=%b, expected gnt=%b sel=%b out=%b valid=%b timeout=%b",
                   t, o.gnt, o.sel, o.out, o.valid, o.timeout,
                   e.gnt, e.sel, e.out, e.valid, e.timeout);
        end
    endtask

    // Drive req, push the expectation, take one edge, sample 1 ns later.
    task automatic step(input logic [3:0] r, input string tag, input logic [3:0] eg,
                        input logic [1:0] es, input logic [WIDTH-1:0] eo,
                        input logic ev, input logic et);
        req = r;
        push_exp(tag, eg, es, eo, ev, et);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        req      = 4'b0000;
        in0      = 4'b1010;
        in1      = 4'b0101;
        in2      = 4'b1100;
        in3      = 4'b0011;

        // Reset state
        #2;
        push_exp("reset_state", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Scenario 1: all request, requester 0 wins first
        step(4'b1111, "s1_first_grant", 4'b0001, 2'd0, 4'b1010, 1'b1, 1'b0);
        step(4'b1111, "s1_hold", 4'b0001, 2'd0, 4'b1010, 1'b1, 1'b0);

        // Scenario 2: handover without gap, then idle keeps sel
        step(4'b1110, "s2_handover", 4'b0010, 2'd1, 4'b0101, 1'b1, 1'b0);
        step(4'b0000, "s2_idle", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, "s2_idle_hold", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0);

        // Scenario 3: last=1, req 0101 -> requester 2 precedes 0
        step(4'b0101, "s3_rr_order", 4'b0100, 2'd2, 4'b1100, 1'b1, 1'b0);
        step(4'b0000, "s3_idle", 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
        // Scenario 4: requester 3 owns 8 cycles, then forced rotation to 1
        for (int i = 0; i < 8; i++) begin
            step(4'b1010, $sformatf("s4_hold_%0d", i), 4'b1000, 2'd3, 4'b0011, 1'b1, 1'b0);
        end
        step(4'b1010, "s4_rotate", 4'b0010, 2'd1, 4'b0101, 1'b1, 1'b1);
        step(4'b1010, "s4_pulse_end", 4'b0010, 2'd1, 4'b0101, 1'b1, 1'b0);
        step(4'b0000, "s4_idle", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b0);
        // Alone, requester 3 keeps the grant past the limit with no pulse
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, $sformatf("s4_alone_%0d", i), 4'b1000, 2'd3, 4'b0011, 1'b1, 1'b0);
        end
`else
        // Scenario 5: no timeout, requester 3 holds indefinitely
        for (int i = 0; i < 55; i++) begin
            step(4'b1010, $sformatf("s5_hold_%0d", i), 4'b1000, 2'd3, 4'b0011, 1'b1, 1'b0);
        end
`endif
        step(4'b0000, "s45_release", 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b0);

        // Scenario 6: last=3, requester 0 granted, then async reset mid-grant
        step(4'b0001, "s6_grant0", 4'b0001, 2'd0, 4'b1010, 1'b1, 1'b0);
        step(4'b0101, "s6_busy", 4'b0001, 2'd0, 4'b1010, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        push_exp("s6_async_reset", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        push_exp("s6_in_reset", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
        check_pop();
        reset_n = 1'b1;
        step(4'b1000, "s6_after_reset", 4'b1000, 2'd3, 4'b0011, 1'b1, 1'b0);
        step(4'b0000, "s6_final_idle", 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
